bitcrush_sh: RTL and testbench

- Parametrised bit-depth and sample-rate reducer ("crush and hold") for the eurorack-pmod audio path.
- Processes N_CH signed channels of width W under two CV inputs: depth CV sets retained bits; rate CV sets sample-and-hold decimation factor.
- Runs entirely in the clk domain; the codec's sample_clk is treated as an asynchronous strobe source and synchronised internally.
- Sits between the codec sample interface and downstream cores.

---
 rtl/bitcrush_sh.sv | 112 +++++++++++
 tb/tb_bitcrush_sh.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitcrush_sh.sv
// rtl/bitcrush_sh.sv - bit-depth and sample-rate reducer (crush and hold) for the codec sample path
module bitcrush_sh #(
    parameter int W         = 16,
    parameter int N_CH      = 4,
    parameter int MIN_BITS  = 1,
    parameter int RATE_BITS = 5,
    parameter int ROUND     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_clk,
    input  logic                bypass,
    input  logic [W-1:0]        cv_depth,
    input  logic [W-1:0]        cv_rate,
    input  logic [N_CH*W-1:0]   sample_in,
    output logic [N_CH*W-1:0]   sample_out,
    output logic                out_valid
);

    localparam logic signed [W:0] MAX_POS   = {2'b00, {(W-1){1'b1}}};
    localparam logic [W-1:0]      ONE_W     = 1;
    localparam logic [W:0]        ONE_W1    = 1;

    logic                 s1, s2, s3;
    logic                 strobe;
    logic [3:0]           idx;
    logic [31:0]          keep;
    logic [31:0]          shift;
    logic [W-1:0]         mask;
    logic [W:0]           half;
    logic [RATE_BITS-1:0] ridx;
    logic [RATE_BITS-1:0] cnt;
    logic [N_CH*W-1:0]    crushed;
    logic [W-1:0]         x;
    logic [W-1:0]         y;
    logic signed [W:0]    sum;
    logic                 unused_cv_lsbs;

    assign strobe = s2 & ~s3;
    assign unused_cv_lsbs = ^{cv_depth[W-6:0], cv_rate[W-2-RATE_BITS:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sample_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        idx   = cv_depth[W-1] ? 4'd0 : cv_depth[W-2 -: 4];
        keep  = 32'(MIN_BITS) + 32'(idx);
        if (keep > 32'(W)) begin
            keep = 32'(W);
        end
        shift = 32'(W) - keep;
        mask  = ~((ONE_W << shift) - ONE_W);
        half  = (ONE_W1 << shift) >> 1;
        ridx  = cv_rate[W-1] ? '0 : cv_rate[W-2 -: RATE_BITS];
    end

    // Rounding adds half an LSB one bit wider so the positive overflow can be caught and clamped.
    always_comb begin
        crushed = '0;
        x       = '0;
        y       = '0;
        sum     = '0;
        for (int c = 0; c < N_CH; c++) begin
            x   = sample_in[c*W +: W];
            sum = $signed({x[W-1], x}) + $signed(half);
            if (ROUND != 0 && shift != 32'd0) begin
                if (sum > MAX_POS) begin
                    y = MAX_POS[W-1:0] & mask;
                end else begin
                    y = sum[W-1:0] & mask;
                end
            end else begin
                y = x & mask;
            end
            crushed[c*W +: W] = y;
        end
    end

    // Hold divisor is loaded only at capture, so CV moves mid-hold wait for the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sample_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (strobe) begin
                if (bypass) begin
                    sample_out <= sample_in;
                    out_valid  <= 1'b1;
                    cnt        <= '0;
                end else if (cnt == '0) begin
                    sample_out <= crushed;
                    out_valid  <= 1'b1;
                    cnt        <= ridx;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitcrush_sh.sv
// tb/tb_bitcrush_sh.sv - vector table, corner sequences and randomized model check for bitcrush_sh
module tb_bitcrush_sh;

    localparam int W    = 16;
    localparam int N    = 4;
    localparam int MINB = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_clk = 1'b0;
    logic        bypass = 1'b0;
    logic [15:0] cv_depth = '0;
    logic [15:0] cv_rate = '0;
    logic [63:0] sample_in = '0;
    logic [63:0] out0, out1;
    logic        v0, v1;

    always #5 clk = ~clk;

    bitcrush_sh #(.W(W), .N_CH(N), .MIN_BITS(MINB), .RATE_BITS(5), .ROUND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .bypass(bypass),
        .cv_depth(cv_depth), .cv_rate(cv_rate), .sample_in(sample_in),
        .sample_out(out0), .out_valid(v0)
    );

    bitcrush_sh #(.W(W), .N_CH(N), .MIN_BITS(MINB), .RATE_BITS(5), .ROUND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .bypass(bypass),
        .cv_depth(cv_depth), .cv_rate(cv_rate), .sample_in(sample_in),
        .sample_out(out1), .out_valid(v1)
    );

    typedef struct {
        logic [15:0] cvd;
        logic [63:0] din;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    vec_t tbl[4];

    int tests = 0;
    int fails = 0;

    int n0, n1, at;
    int strobe_n = 0;
    int next_cap = 0;
    logic [63:0] m0 = '0;
    logic [63:0] m1 = '0;
    bit m_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_crush(input logic [15:0] xin, input logic [15:0] cvd, input bit rnd);
        int keep, s, v;
        logic [31:0] r;
        keep = cvd[15] ? MINB : MINB + int'(cvd[14:11]);
        if (keep > W) keep = W;
        s = W - keep;
        v = int'($signed(xin));
        if (rnd && s > 0) begin
            v = v + (1 << (s - 1));
            if (v > 32767) v = 32767;
        end
        v = (v >>> s) <<< s;
        r = v;
        return r[15:0];
    endfunction

    function automatic int ref_div(input logic [15:0] cvr);
        return cvr[15] ? 1 : int'(cvr[14:10]) + 1;
    endfunction

    // Reference: a capture happens when the strobe index reaches the scheduled one.
    task automatic model_step();
        if (bypass) begin
            m0 = sample_in;
            m1 = sample_in;
            m_v = 1'b1;
            next_cap = strobe_n + 1;
        end else if (strobe_n >= next_cap) begin
            for (int c = 0; c < N; c++) begin
                m0[c*16 +: 16] = ref_crush(sample_in[c*16 +: 16], cv_depth, 1'b0);
                m1[c*16 +: 16] = ref_crush(sample_in[c*16 +: 16], cv_depth, 1'b1);
            end
            m_v = 1'b1;
            next_cap = strobe_n + ref_div(cv_rate);
        end else begin
            m_v = 1'b0;
        end
        strobe_n++;
    endtask

    task automatic model_reset();
        next_cap = strobe_n;
        m0 = '0;
        m1 = '0;
    endtask

    task automatic pulse();
        model_step();
        sample_clk = 1'b1;
        n0 = 0;
        n1 = 0;
        at = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (v0) begin
                n0++;
                if (at < 0) at = i;
            end
            if (v1) n1++;
        end
        sample_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] capmask;
        logic [63:0] last;
        logic [63:0] a_val, b_val, c_val, raw;
        int cnt;

        tbl[0] = '{16'h7FFF, {16'h0000, 16'h0000, 16'h1234, 16'h0000},
                   {16'h0000, 16'h0000, 16'h1234, 16'h0000},
                   {16'h0000, 16'h0000, 16'h1234, 16'h0000}};
        tbl[1] = '{16'h0000, {16'h0000, 16'h0001, 16'h8001, 16'h7FFF},
                   {16'h0000, 16'h0000, 16'h8000, 16'h0000},
                   {16'h0000, 16'h0000, 16'h8000, 16'h0000}};
        tbl[2] = '{16'h4000, {16'hFFBF, 16'h00C0, 16'h7FF0, 16'h1234},
                   {16'hFF80, 16'h0080, 16'h7F80, 16'h1200},
                   {16'hFF80, 16'h0100, 16'h7F80, 16'h1200}};
        tbl[3] = '{16'hFFFF, {16'h8000, 16'hFFFF, 16'h4000, 16'hC000},
                   {16'h8000, 16'h8000, 16'h0000, 16'h8000},
                   {16'h8000, 16'h0000, 16'h0000, 16'h0000}};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out0", out0, 64'h0);
        chk("reset_out1", out1, 64'h0);
        chk("reset_valid", {62'h0, v1, v0}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();

        cv_rate = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            cv_depth  = tbl[i].cvd;
            sample_in = tbl[i].din;
            pulse();
            chk($sformatf("vec%0d_valid_count", i), 64'(n0), 64'd1);
            chk($sformatf("vec%0d_latency", i), 64'(at), 64'd3);
            chk($sformatf("vec%0d_trunc", i), out0, tbl[i].e0);
            chk($sformatf("vec%0d_round", i), out1, tbl[i].e1);
        end

        for (int pass = 0; pass < 2; pass++) begin
            reset_dut();
            cv_depth = 16'h7FFF;
            cv_rate  = 16'h0C00;
            capmask  = (pass == 0) ? 12'b0001_0001_0001 : 12'b1111_0001_0001;
            last     = '0;
            for (int k = 1; k <= 12; k++) begin
                if (pass == 1 && k == 6) cv_rate = 16'h8000;
                sample_in = {4{16'(k * 257)}};
                pulse();
                if (capmask[k-1]) last = sample_in;
                chk($sformatf("rate%0d_s%0d_valid", pass, k), 64'(n0), 64'(capmask[k-1]));
                chk($sformatf("rate%0d_s%0d_out", pass, k), out0, last);
            end
        end

        cv_rate = 16'h8000;
        cnt = 0;
        sample_clk = 1'b1;
        repeat (100) begin @(negedge clk); if (v0) cnt++; end
        sample_clk = 1'b0;
        repeat (5) begin @(negedge clk); if (v0) cnt++; end
        sample_clk = 1'b1;
        repeat (10) begin @(negedge clk); if (v0) cnt++; end
        sample_clk = 1'b0;
        repeat (5) begin @(negedge clk); if (v0) cnt++; end
        chk("held_high_pulses", 64'(cnt), 64'd2);

        reset_dut();
        cv_depth = 16'h7FFF;
        cv_rate  = 16'h0C00;
        a_val = 64'h1111_2222_3333_4444;
        b_val = 64'h5555_6666_7777_0888;
        c_val = 64'h0ABC_0DEF_1357_2468;
        sample_in = a_val;
        pulse();
        chk("midhold_first_valid", 64'(n0), 64'd1);
        sample_in = b_val;
        pulse();
        chk("midhold_hold_valid", 64'(n0), 64'd0);
        chk("midhold_hold_out", out0, a_val);
        rst_n = 1'b0;
        #1;
        chk("midhold_reset_out", out0, 64'h0);
        chk("midhold_reset_valid", {63'h0, v0}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        sample_in = c_val;
        pulse();
        chk("post_reset_valid", 64'(n0), 64'd1);
        chk("post_reset_out", out0, c_val);

        cv_depth = 16'h0000;
        cv_rate  = 16'h7C00;
        bypass   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            raw = {$urandom, $urandom};
            sample_in = raw;
            pulse();
            chk($sformatf("bypass%0d_valid", k), 64'(n0), 64'd1);
            chk($sformatf("bypass%0d_out0", k), out0, raw);
            chk($sformatf("bypass%0d_out1", k), out1, raw);
        end
        bypass = 1'b0;
        sample_in = {$urandom, $urandom};
        pulse();
        chk("unbypass_valid", 64'(n0), 64'd1);
        chk("unbypass_out0", out0, m0);
        sample_in = {$urandom, $urandom};
        pulse();
        chk("unbypass_hold_valid", 64'(n0), 64'd0);

        for (int k = 0; k < 200; k++) begin
            cv_depth  = 16'($urandom);
            if ($urandom_range(0, 3) == 0)
                cv_rate = 16'($urandom);
            else
                cv_rate = {1'b0, 5'($urandom_range(0, 3)), 10'($urandom)};
            bypass    = ($urandom_range(0, 9) == 0);
            sample_in = {$urandom, $urandom};
            pulse();
            chk($sformatf("rand%0d_valid0", k), 64'(n0), 64'(m_v));
            chk($sformatf("rand%0d_valid1", k), 64'(n1), 64'(m_v));
            chk($sformatf("rand%0d_out0", k), out0, m0);
            chk($sformatf("rand%0d_out1", k), out1, m1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
